// File: rtl/mul_wb_seq.sv
// Iterative shift-add multiplier feeding the register file write port.
// A W-cycle multiply is followed by two write-back cycles: the low half goes to
// dest and the high half to dest+1 (wrapping within 2**D registers).
module mul_wb_seq #(
  parameter int unsigned W = 8,
  parameter int unsigned D = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic [D-1:0] dest,
  output logic         busy,
  output logic         done,
  output logic         wr_en,
  output logic [D-1:0] wr_addr,
  output logic [W-1:0] wr_data
);

  localparam int unsigned CW = $clog2(W) + 1;
  localparam logic [CW-1:0] CntLast = CW'(W - 1);
  localparam logic [CW-1:0] CntOne  = CW'(1);
  localparam logic [D-1:0]  DstOne  = D'(1);

  typedef enum logic [1:0] {StIdle, StRun, StWbLo, StWbHi} state_e;

  state_e          state_q, state_d;
  logic [2*W-1:0]  mcand_q;
  logic [W-1:0]    mplier_q;
  logic [2*W-1:0]  prod_q;
  logic [CW-1:0]   cnt_q;
  logic [D-1:0]    dst_q;

  // Next-state: fixed W run cycles, then two write-back cycles.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (cnt_q == CntLast) state_d = StWbLo;
      StWbLo:  state_d = StWbHi;
      StWbHi:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; operands latch only when a start is taken in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      dst_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && start) begin
        mcand_q  <= {{W{1'b0}}, a_in};
        mplier_q <= b_in;
        dst_q    <= dest;
        prod_q   <= '0;
        cnt_q    <= '0;
      end else if (state_q == StRun) begin
        if (mplier_q[0]) prod_q <= prod_q + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + CntOne;
      end
    end
  end

  // Outputs decode registered state only; write data/address are zero when not writing.
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    unique case (state_q)
      StRun: busy = 1'b1;
      StWbLo: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = dst_q;
        wr_data = prod_q[W-1:0];
      end
      StWbHi: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        done    = 1'b1;
        wr_addr = dst_q + DstOne;
        wr_data = prod_q[2*W-1:W];
      end
      default: ;
    endcase
  end

endmodule

// File: doc/mul_wb_seq.md
Name: mul_wb_seq

Overview:
Iterative shift-add multiplier that sits directly upstream of the register file write port.
- Consumes two register-file read operands (A, B) and a destination index.
- Produces a 2W-bit product over W cycles.
- Writes the product back through the register file's single write port as two consecutive writes: low half to dest, high half to dest+1.
- The control unit starts it and stalls on busy.

Parameters:
W, 8, operand / register data width
D, 3, register address width (2**D addressable registers)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request a multiply; sampled only in IDLE
a_in  input  W  multiplicand (from register file read port A)
b_in  input  W  multiplier (from register file read port B)
dest  input  D  destination register for the low half; high half goes to (dest+1) mod 2**D
busy  output  1  high in RUN, WB_LO, WB_HI
done  output  1  one-cycle pulse, high during WB_HI
wr_en  output  1  drives register file write_en
wr_addr  output  D  drives register file waddr
wr_data  output  W  drives register file data_in

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- State register: IDLE, RUN, WB_LO, WB_HI.
- Internal registers:
  - mcand (2W bits, zero-extended a_in)
  - mplier (W bits)
  - prod (2W bits)
  - cnt (clog2(W)+1 bits)
  - dst (D bits)
- Outputs are decoded from registered state and registers only; no combinational path from any input to any output.
- Reset (sampled at a clk edge): state=IDLE, prod=0, cnt=0.
  - In IDLE: busy=0, done=0, wr_en=0, wr_addr=0, wr_data=0.
  - Reset overrides start on the same edge.
- IDLE:
  - If start=1 at an edge: latch mcand={W'0,a_in}, mplier=b_in, dst=dest; clear prod and cnt; go to RUN.
  - Else stay in IDLE.
- RUN, each cycle:
  - If mplier[0], prod <= prod + mcand (2W-bit add; no overflow is possible).
  - mcand <= mcand<<1; mplier <= mplier>>1; cnt <= cnt+1.
  - After exactly W RUN cycles go to WB_LO. There is no early exit on zero operands, so latency is fixed.
- WB_LO (1 cycle): wr_en=1, wr_addr=dst, wr_data=prod[W-1:0]. Next state WB_HI.
- WB_HI (1 cycle): wr_en=1, wr_addr=dst+1 (D-bit wrap: 2**D-1 -> 0), wr_data=prod[2W-1:W], done=1. Next state IDLE.
- Outside WB_LO/WB_HI: wr_en=0, wr_addr=0, wr_data=0.
- Latency, with start high in cycle 0:
  - RUN in cycles 1..W.
  - Low write in cycle W+1 (committed at the end of that cycle).
  - High write plus done in cycle W+2.
  - IDLE in cycle W+3, where a new start is accepted.
  - Back-to-back issue interval is W+3 cycles.
- Start while busy=1: ignored, not queued. a_in/b_in/dest changes during busy have no effect.
- start held high continuously: a new operation is accepted on every IDLE cycle, i.e. every W+3 cycles.
- Reset mid-operation (any non-IDLE state):
  - Next cycle is IDLE with all outputs 0.
  - Any write not yet performed is abandoned.
  - If reset is asserted during WB_HI, the low write has already committed and the high write still occurs in that cycle, because outputs decode current state.
- dest = 2**D-1: the high half writes register 0. The register file accepts writes to address 0.
- Operands of 0: the operation still takes the full W cycles and writes 0 to both registers.
- The multiplier never drives write addresses at or above 2**D. The extra register-file entry at index 2**D is not reachable from this block.

Test Plan:
- Reset, then a_in=13, b_in=11, dest=2, start pulse in cycle 0 -> busy cycles 1-10; cycle 9: wr_en=1, wr_addr=2, wr_data=0x8F; cycle 10: wr_en=1, wr_addr=3, wr_data=0x00, done=1; cycle 11: busy=0.
- a_in=255, b_in=255, dest=7 -> cycle 9 writes 0x01 to reg 7; cycle 10 writes 0xFE to reg 0 (wrap); done=1 in cycle 10 only.
- a_in=0, b_in=200, dest=4 -> still 8 RUN cycles; writes 0x00 to regs 4 and 5; done in cycle 10.
- start pulsed in cycle 3 with a_in=1, b_in=1, dest=6 during an active 13x11 op -> ignored; results and addresses of the original op unchanged; no extra writes.
- reset asserted in cycle 5 of an op -> cycle 6: busy=0, wr_en=0, done=0; no writes ever issued for that op; a new start in cycle 6 completes normally (done in cycle 16).
- start held high constantly with a_in=2, b_in=3, dest=1 -> done in cycles 10, 21, 32; each op writes 0x06 to reg 1 and 0x00 to reg 2.
